uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, max cycles the WAIT_BUSY state waits for tx_done to fall (used only under REQ-027).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: req0_valid  input  1  requester 0 has a byte to send.
REQ-005 Port: req0_byte  input  8  requester 0 data.
REQ-006 Port: req0_ready  output  1  requester 0 byte accepted this cycle.
REQ-007 Port: req1_valid  input  1  requester 1 has a byte to send.
REQ-008 Port: req1_byte  input  8  requester 1 data.
REQ-009 Port: req1_ready  output  1  requester 1 byte accepted this cycle.
REQ-010 Port: tx_start  output  1  one-cycle launch strobe to the UART transmitter.
REQ-011 Port: tx_byte  output  8  byte presented to the transmitter.
REQ-012 Port: tx_done  input  1  transmitter idle flag (1 = idle; falls the cycle after tx_start is sampled; rises at end of stop bit).
REQ-013 Port: busy  output  1  arbiter not in IDLE.
REQ-014 Port: last_grant  output  1  index of the most recently granted requester.
REQ-015 Port: err  output  1  one-cycle timeout pulse (REQ-027); constant 0 otherwise.

Function
REQ-016 FSM states SHALL be IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE; transitions only as REQ-017..REQ-022.
REQ-017 reqN_ready SHALL be combinational: high only when state==IDLE, tx_done==1, reqN_valid==1, and N wins arbitration; transfer occurs on valid&ready.
REQ-018 Arbitration: one valid -> that port wins; both valid -> port != last_grant wins (round-robin); at most one ready high per cycle.
REQ-019 On transfer, the winning byte SHALL be registered into tx_byte, last_grant SHALL be updated to the winner, and the FSM SHALL go IDLE -> LAUNCH.
REQ-020 LAUNCH: tx_start=1 for exactly that one cycle (transfer at cycle N -> tx_start high at cycle N+1); then -> WAIT_BUSY.
REQ-021 WAIT_BUSY: stay until tx_done==0, then -> WAIT_DONE.
REQ-022 WAIT_DONE: stay until tx_done==1, then -> IDLE; earliest next transfer is the cycle after re-entering IDLE.
REQ-023 tx_byte SHALL hold stable from LAUNCH until the next transfer; tx_start SHALL be 0 in every state except LAUNCH.
REQ-024 In IDLE with tx_done==0 (transmitter still busy, e.g. after reset), no ready SHALL assert.
REQ-025 valid deasserted before ready: no state change, last_grant unchanged; requester data need not be held once ready has been seen.
REQ-026 busy = (state != IDLE), combinational from the state register.

Configuration
REQ-027 Macro UART_TX_ARB_TIMEOUT_EN: when defined, a counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT_BUSY and increments each WAIT_BUSY cycle; when it reaches TIMEOUT_CYCLES with tx_done still 1, the FSM SHALL go to IDLE, err SHALL pulse 1 for one cycle, and the byte is dropped. When the macro is undefined, there is no counter, WAIT_BUSY waits indefinitely, and err is tied 0.

Reset
REQ-028 rst high SHALL immediately (asynchronously) force state=IDLE, tx_start=0, tx_byte=8'h00, last_grant=1 (port 0 gets first grant), err=0, timeout counter=0; ready outputs are then governed by REQ-017.
REQ-029 Reset mid-transfer SHALL abandon the byte without re-launch; the transmitter frame in flight completes on its own, and REQ-024 blocks new grants until tx_done==1.

Verification
REQ-030 Single: req0_valid with byte 8'hA5, tx_done=1 -> req0_ready 1 cycle, tx_start at +1 cycle with tx_byte=8'hA5, busy until tx_done rises.
REQ-031 Contention: both valid after reset with bytes 8'h11 and 8'h22 -> transmitter receives 8'h11 then 8'h22; last_grant goes 0 then 1.
REQ-032 Fairness: both valid continuously for 6 bytes -> grants alternate 0,1,0,1,0,1; never two tx_start pulses without an intervening tx_done fall/rise.
REQ-033 Busy transmitter: tx_done=0 in IDLE with req1_valid=1 -> no ready until tx_done=1, then req1_ready pulses.
REQ-034 Reset in WAIT_DONE -> tx_start=0, busy=0 immediately; no new tx_start before tx_done returns 1.
REQ-035 With UART_TX_ARB_TIMEOUT_EN, tx_done held 1 after tx_start -> err pulse exactly TIMEOUT_CYCLES cycles after WAIT_BUSY entry (16 with default), FSM back in IDLE; without the macro, err stays 0 and busy stays 1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter that feeds bytes to one UART transmitter.
// Optional WAIT_BUSY timeout is compiled in with `define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_byte,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_byte,
  output logic       req1_ready,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  input  logic       tx_done,
  output logic       busy,
  output logic       last_grant,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e     state_q, state_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       last_grant_q, last_grant_d;
  logic       tx_start_q, tx_start_d;
  logic       grant0_c, grant1_c, accept_c;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Round-robin: on contention the port that did not win last time gets the grant.
  always_comb begin
    grant0_c = req0_valid & (~req1_valid | last_grant_q);
    grant1_c = req1_valid & (~req0_valid | ~last_grant_q);
    accept_c = (state_q == IDLE) & tx_done;
  end

  assign req0_ready = accept_c & grant0_c;
  assign req1_ready = accept_c & grant1_c;
  assign busy       = (state_q != IDLE);
  assign tx_start   = tx_start_q;
  assign tx_byte    = tx_byte_q;
  assign last_grant = last_grant_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    tx_byte_d    = tx_byte_q;
    last_grant_d = last_grant_q;
    tx_start_d   = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req0_ready) begin
          tx_byte_d    = req0_byte;
          last_grant_d = 1'b0;
          tx_start_d   = 1'b1;
          state_d      = LAUNCH;
        end else if (req1_ready) begin
          tx_byte_d    = req1_byte;
          last_grant_d = 1'b1;
          tx_start_d   = 1'b1;
          state_d      = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT_BUSY;
`ifdef UART_TX_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT_BUSY: begin
        if (!tx_done) begin
          state_d = WAIT_DONE;
        end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
          // Transmitter never picked up the launch: drop the byte and flag it.
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            cnt_d   = '0;
            err_d   = 1'b1;
            state_d = IDLE;
          end
`endif
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tx_byte_q    <= 8'h00;
      last_grant_q <= 1'b1;
      tx_start_q   <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tx_byte_q    <= tx_byte_d;
      last_grant_q <= last_grant_d;
      tx_start_q   <= tx_start_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a launch scoreboard and a simple transmitter model.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_byte = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_byte = 8'h00;
  logic       req1_ready;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_done = 1'b1;
  logic       busy;
  logic       last_grant;
  logic       err;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_byte  (req0_byte),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_byte  (req1_byte),
    .req1_ready (req1_ready),
    .tx_start   (tx_start),
    .tx_byte    (tx_byte),
    .tx_done    (tx_done),
    .busy       (busy),
    .last_grant (last_grant),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       g;
    logic [7:0] b;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic auto_tx   = 1'b1;
  int   frm       = 0;
  logic prev_start = 1'b0;
  logic lg_m      = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Launch monitor, then transmitter model: tx_done drops after a launch and returns after a short frame.
  always @(negedge clk) begin
    if (tx_start) begin
      check("start_single_cycle", prev_start, 0);
      check("start_while_tx_idle", tx_done, 1);
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("sb_tx_byte", tx_byte, mon_e.b);
        check("sb_last_grant", last_grant, mon_e.g);
      end
    end
    prev_start = tx_start;
    if (auto_tx) begin
      if (tx_start) begin
        tx_done = 1'b0;
        frm     = 3;
      end else if (!tx_done) begin
        if (frm == 0) tx_done = 1'b1;
        else frm--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(busy === 1'b0 && tx_done === 1'b1) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    lg_m = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Both ports stream n0/n1 bytes; each grant is checked against the round-robin model.
  task automatic run_traffic(input int n0, input int n1, input logic [7:0] b0, input logic [7:0] b1);
    int   i0 = 0;
    int   i1 = 0;
    int   cyc = 0;
    logic w;
    while ((i0 < n0 || i1 < n1) && cyc < 400) begin
      @(negedge clk);
      req0_valid = (i0 < n0);
      req0_byte  = b0 + 8'(i0);
      req1_valid = (i1 < n1);
      req1_byte  = b1 + 8'(i1);
      #1;
      if (req0_ready || req1_ready) begin
        w = (req0_valid && req1_valid) ? ~lg_m : req1_valid;
        check("ready_onehot", {req1_ready, req0_ready}, w ? 2 : 1);
        check("ready_needs_tx_idle", tx_done, 1);
        sb.push_back({w, w ? req1_byte : req0_byte});
        lg_m = w;
        if (w) i1++;
        else i0++;
      end
      cyc++;
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("traffic_sent", i0 + i1, n0 + n1);
    wait_idle("traffic_idle");
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_last_grant", last_grant, 1);
    check("rst_err", err, 0);
    check("rst_ready0", req0_ready, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single byte, exact launch latency
    @(negedge clk);
    req0_valid = 1'b1;
    req0_byte  = 8'hA5;
    #1;
    check("single_ready0", req0_ready, 1);
    check("single_ready1", req1_ready, 0);
    check("single_idle_busy", busy, 0);
    sb.push_back({1'b0, 8'hA5});
    lg_m = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check("single_tx_start", tx_start, 1);
    check("single_tx_byte", tx_byte, 8'hA5);
    check("single_busy", busy, 1);
    check("single_ready_in_launch", req0_ready, 0);
    wait_idle("single_idle");
    check("single_start_low", tx_start, 0);
    check("single_byte_held", tx_byte, 8'hA5);

    // Contention straight after reset: port 0 first, then port 1
    do_reset();
    run_traffic(1, 1, 8'h11, 8'h22);
    check("contention_last_grant", last_grant, 1);

    // Fairness under continuous contention: six alternating grants
    run_traffic(3, 3, 8'h30, 8'h40);
    check("fair_last_grant", last_grant, 1);

    // Transmitter busy while IDLE holds off the grant
    auto_tx = 1'b0;
    @(negedge clk);
    tx_done    = 1'b0;
    req1_valid = 1'b1;
    req1_byte  = 8'h5C;
    repeat (4) begin
      @(negedge clk);
      #1;
      check("txbusy_no_ready1", req1_ready, 0);
      check("txbusy_no_ready0", req0_ready, 0);
    end
    @(negedge clk);
    tx_done = 1'b1;
    #1;
    check("txbusy_ready1", req1_ready, 1);
    sb.push_back({1'b1, 8'h5C});
    lg_m    = 1'b1;
    auto_tx = 1'b1;
    @(negedge clk);
    req1_valid = 1'b0;
    wait_idle("txbusy_idle");

    // Reset while waiting for the frame to finish
    @(negedge clk);
    req0_valid = 1'b1;
    req0_byte  = 8'h7E;
    #1;
    check("rstwd_ready0", req0_ready, 1);
    sb.push_back({1'b0, 8'h7E});
    lg_m = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    auto_tx = 1'b0;
    #1;
    check("rstwd_pre_busy", busy, 1);
    check("rstwd_pre_txdone", tx_done, 0);
    rst = 1'b1;
    #1;
    check("rstwd_tx_start", tx_start, 0);
    check("rstwd_busy", busy, 0);
    check("rstwd_last_grant", last_grant, 1);
    check("rstwd_tx_byte", tx_byte, 8'h00);
    lg_m = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    req0_valid = 1'b1;
    req0_byte  = 8'h3C;
    repeat (4) begin
      #1;
      check("rstwd_no_ready", req0_ready, 0);
      check("rstwd_no_start", tx_start, 0);
      @(negedge clk);
    end
    tx_done = 1'b1;
    #1;
    check("rstwd_ready_after_done", req0_ready, 1);
    sb.push_back({1'b0, 8'h3C});
    lg_m    = 1'b0;
    auto_tx = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    wait_idle("rstwd_idle");

    // Transmitter never reacts to the launch
    auto_tx = 1'b0;
    @(negedge clk);
    tx_done    = 1'b1;
    req1_valid = 1'b1;
    req1_byte  = 8'hE7;
    #1;
    check("tmo_ready1", req1_ready, 1);
    sb.push_back({1'b1, 8'hE7});
    lg_m = 1'b1;
    @(negedge clk);
    req1_valid = 1'b0;
    repeat (16) begin
      @(negedge clk);
      #1;
      check("tmo_err_low", err, 0);
      check("tmo_busy_high", busy, 1);
    end
    @(negedge clk);
    #1;
`ifdef UART_TX_ARB_TIMEOUT_EN
    check("tmo_err_pulse", err, 1);
    check("tmo_back_idle", busy, 0);
`else
    check("tmo_err_tied", err, 0);
    check("tmo_still_busy", busy, 1);
`endif
    @(negedge clk);
    #1;
    check("tmo_err_one_cycle", err, 0);
    do_reset();
    auto_tx = 1'b1;
    #1;
    check("final_busy", busy, 0);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
